// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Constants shared by the FFT frame-side blocks (fft_out_serializer today,
//   fft_in_deserializer later): frame geometry and the serializer FSM encoding.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int unsigned FFT_PTS  = 32;
    localparam int unsigned FFT_N    = 16;
    localparam int unsigned FFT_IDXW = $clog2(FFT_PTS);

    // Raw encodings, kept as localparams so other blocks can share them.
    localparam logic S_IDLE   = 1'b0;
    localparam logic S_STREAM = 1'b1;

    typedef enum logic {
        ST_IDLE   = S_IDLE,
        ST_STREAM = S_STREAM
    } ser_state_e;

endpackage : fft_pkg

// File: rtl/fft_out_serializer_if.sv
// -----------------------------------------------------------------------------
// fft_out_serializer_if
//   Load handshake (parallel frame in) and stream handshake (one bin out)
//   for the FFT output serializer.
//   Signals:
//     ld_valid / ld_ready / ld_r / ld_i   parallel frame load
//     so_valid / so_ready / so_r / so_i / so_last   bin stream
//     so_idx   bin index (only when FFT_SER_IDX_EN is defined)
//   Modports:
//     master  the serializer side
//     slave   the producer/consumer environment side
// -----------------------------------------------------------------------------
interface fft_out_serializer_if #(
    parameter int unsigned N   = fft_pkg::FFT_N,
    parameter int unsigned PTS = fft_pkg::FFT_PTS
);

    logic             ld_valid;
    logic             ld_ready;
    logic [PTS*N-1:0] ld_r;
    logic [PTS*N-1:0] ld_i;

    logic             so_valid;
    logic             so_ready;
    logic [N-1:0]     so_r;
    logic [N-1:0]     so_i;
    logic             so_last;
`ifdef FFT_SER_IDX_EN
    localparam int unsigned IDXW = $clog2(PTS);
    logic [IDXW-1:0]  so_idx;
`endif

    modport master (
        input  ld_valid,
        output ld_ready,
        input  ld_r,
        input  ld_i,
        output so_valid,
        input  so_ready,
        output so_r,
        output so_i,
        output so_last
`ifdef FFT_SER_IDX_EN
        ,
        output so_idx
`endif
    );

    modport slave (
        output ld_valid,
        input  ld_ready,
        output ld_r,
        output ld_i,
        input  so_valid,
        output so_ready,
        input  so_r,
        input  so_i,
        input  so_last
`ifdef FFT_SER_IDX_EN
        ,
        input  so_idx
`endif
    );

endinterface : fft_out_serializer_if

// File: rtl/fft_out_serializer_frame_buf.sv
// -----------------------------------------------------------------------------
// fft_frame_buf
//   PTS x 2N capture registers for one FFT frame. All bins are written in one
//   clock when we=1; one bin is read combinationally at rd_idx.
//   Ports:
//     clk2          clock
//     we            capture the whole frame from wr_r/wr_i
//     wr_r, wr_i    packed frame, bin k at [k*N +: N]
//     rd_idx        bin to read
//     rd_r, rd_i    bin at rd_idx
//   Pure datapath storage: contents are only observed after a capture, so the
//   registers carry no reset.
// -----------------------------------------------------------------------------
module fft_frame_buf import fft_pkg::*; #(
    parameter int unsigned N   = FFT_N,
    parameter int unsigned PTS = FFT_PTS
) (
    input  logic                     clk2,
    input  logic                     we,
    input  logic [PTS*N-1:0]         wr_r,
    input  logic [PTS*N-1:0]         wr_i,
    input  logic [$clog2(PTS)-1:0]   rd_idx,
    output logic [N-1:0]             rd_r,
    output logic [N-1:0]             rd_i
);

    logic [N-1:0] mem_r [PTS];
    logic [N-1:0] mem_i [PTS];

    // Write-all capture.
    always_ff @(posedge clk2) begin
        if (we) begin
            for (int unsigned k = 0; k < PTS; k++) begin
                mem_r[k] <= wr_r[k*N +: N];
                mem_i[k] <= wr_i[k*N +: N];
            end
        end
    end

    // Indexed read; PTS is a power of two so rd_idx is always in range.
    assign rd_r = mem_r[rd_idx];
    assign rd_i = mem_i[rd_idx];

endmodule : fft_frame_buf

// File: rtl/fft_out_serializer.sv
// -----------------------------------------------------------------------------
// fft_out_serializer
//   Captures one parallel FFT frame on the load handshake and streams its bins
//   in natural order 0..PTS-1, one per clock, over a valid/ready interface.
//   Ports:
//     clk2   clock (rising edge)
//     rst    asynchronous active-high reset
//     bus    fft_out_serializer_if.master (load + stream handshakes)
//     ovf    sticky: a load was offered while not ready
//   Configuration:
//     FFT_SER_IDX_EN  when defined, bus.so_idx carries the current bin index.
// -----------------------------------------------------------------------------
module fft_out_serializer import fft_pkg::*; #(
    parameter int unsigned N   = FFT_N,
    parameter int unsigned PTS = FFT_PTS
) (
    input  logic                 clk2,
    input  logic                 rst,
    fft_out_serializer_if.master bus,
    output logic                 ovf
);

    localparam int unsigned     IDXW     = $clog2(PTS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PTS - 1);

    ser_state_e      state_q, state_d;
    logic [IDXW-1:0] count_q, count_d;
    logic            ld_ready_q, ld_ready_d;
    logic            so_valid_q, so_valid_d;
    logic [N-1:0]    so_r_q, so_r_d;
    logic [N-1:0]    so_i_q, so_i_d;
    logic            so_last_q, so_last_d;
    logic            ovf_q, ovf_d;

    logic            buf_we;
    logic [IDXW-1:0] rd_idx;
    logic [N-1:0]    rd_r;
    logic [N-1:0]    rd_i;

    // The buffer is read one bin ahead so the output data can be registered.
    assign rd_idx = count_q + IDXW'(1);

    fft_frame_buf #(
        .N   (N),
        .PTS (PTS)
    ) u_frame_buf (
        .clk2   (clk2),
        .we     (buf_we),
        .wr_r   (bus.ld_r),
        .wr_i   (bus.ld_i),
        .rd_idx (rd_idx),
        .rd_r   (rd_r),
        .rd_i   (rd_i)
    );

    // State, counter and registered outputs.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            ld_ready_q <= 1'b1;
            so_valid_q <= 1'b0;
            so_r_q     <= '0;
            so_i_q     <= '0;
            so_last_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ld_ready_q <= ld_ready_d;
            so_valid_q <= so_valid_d;
            so_r_q     <= so_r_d;
            so_i_q     <= so_i_d;
            so_last_q  <= so_last_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ld_ready_d = ld_ready_q;
        so_valid_d = so_valid_q;
        so_r_d     = so_r_q;
        so_i_d     = so_i_q;
        so_last_d  = so_last_q;
        buf_we     = 1'b0;
        // ld_ready_q is high exactly in IDLE, so this flags any load offered mid-stream.
        ovf_d      = ovf_q | (bus.ld_valid & ~ld_ready_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.ld_valid) begin
                    buf_we     = 1'b1;
                    state_d    = ST_STREAM;
                    count_d    = '0;
                    ld_ready_d = 1'b0;
                    so_valid_d = 1'b1;
                    // Bin 0 bypasses the buffer so it is visible right after capture.
                    so_r_d     = bus.ld_r[0 +: N];
                    so_i_d     = bus.ld_i[0 +: N];
                    so_last_d  = 1'b0;
                end
            end

            ST_STREAM: begin
                if (bus.so_ready) begin
                    if (count_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        count_d    = '0;
                        ld_ready_d = 1'b1;
                        so_valid_d = 1'b0;
                        so_r_d     = '0;
                        so_i_d     = '0;
                        so_last_d  = 1'b0;
                    end else begin
                        count_d    = rd_idx;
                        so_r_d     = rd_r;
                        so_i_d     = rd_i;
                        so_last_d  = (rd_idx == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ld_ready = ld_ready_q;
    assign bus.so_valid = so_valid_q;
    assign bus.so_r     = so_r_q;
    assign bus.so_i     = so_i_q;
    assign bus.so_last  = so_last_q;
    assign ovf          = ovf_q;

`ifdef FFT_SER_IDX_EN
    // count_q is the index of the presented bin and is 0 whenever idle.
    assign bus.so_idx   = count_q;
`endif

endmodule : fft_out_serializer

// File: tb/tb_fft_out_serializer.sv
// -----------------------------------------------------------------------------
// tb_fft_out_serializer
//   Directed bench for fft_out_serializer: reset, ramp frame, backpressure,
//   overrun, reset mid-stream and back-to-back frames.
// -----------------------------------------------------------------------------
module tb_fft_out_serializer;
    import fft_pkg::*;

    localparam int unsigned N   = FFT_N;
    localparam int unsigned PTS = FFT_PTS;

    logic clk2 = 1'b0;
    logic rst;
    logic ovf;

    int n_checks = 0;
    int n_errors = 0;

    fft_out_serializer_if #(.N(N), .PTS(PTS)) bus ();

    fft_out_serializer #(.N(N), .PTS(PTS)) dut (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (bus),
        .ovf  (ovf)
    );

    always #5 clk2 = ~clk2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame contents by kind; kind 2 is the junk frame offered during overrun.
    function automatic logic [N-1:0] bin_r(input int kind, input int k);
        case (kind)
            0:       return N'(k);
            1:       return N'(32'h1000 + 3 * k);
            2:       return 16'hDEAD;
            3:       return N'(32'h7FFF - k);
            default: return N'(257 * k);
        endcase
    endfunction

    function automatic logic [N-1:0] bin_i(input int kind, input int k);
        case (kind)
            0:       return N'(-k);
            1:       return N'(32'hF0F0 ^ k);
            2:       return 16'hBEEF;
            3:       return N'(32'h8000 + 5 * k);
            default: return N'(-2 * k);
        endcase
    endfunction

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    task automatic drive_frame(input int kind);
        for (int k = 0; k < int'(PTS); k++) begin
            bus.ld_r[k*N +: N] = bin_r(kind, k);
            bus.ld_i[k*N +: N] = bin_i(kind, k);
        end
    endtask

    task automatic load_frame(input int kind);
        drive_frame(kind);
        check("ld_ready_before_load", 32'(bus.ld_ready), 32'd1);
        bus.ld_valid = 1'b1;
        step();
        bus.ld_valid = 1'b0;
    endtask

    task automatic check_bin(input int kind, input int k);
        check($sformatf("k%0d_valid", k), 32'(bus.so_valid), 32'd1);
        check($sformatf("k%0d_r", k), 32'(bus.so_r), 32'(bin_r(kind, k)));
        check($sformatf("k%0d_i", k), 32'(bus.so_i), 32'(bin_i(kind, k)));
        check($sformatf("k%0d_last", k), 32'(bus.so_last), (k == int'(PTS) - 1) ? 32'd1 : 32'd0);
`ifdef FFT_SER_IDX_EN
        check($sformatf("k%0d_idx", k), 32'(bus.so_idx), 32'(k));
`endif
    endtask

    // Streams one frame with so_ready high except for an optional stall.
    // stop_at >= 0 returns right after checking that bin, leaving it presented.
    task automatic stream_frame(input int kind, input int stall_at, input int stall_len,
                                input int ovf_at, input int stop_at);
        bus.so_ready = 1'b1;
        for (int k = 0; k < int'(PTS); k++) begin
            check_bin(kind, k);
            if (k == 0) check("ld_ready_streaming", 32'(bus.ld_ready), 32'd0);
            if (k == stop_at) return;
            if (k == stall_at) begin
                bus.so_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    check_bin(kind, k);
                end
                bus.so_ready = 1'b1;
            end
            if (k == ovf_at) begin
                drive_frame(2);
                bus.ld_valid = 1'b1;
                step();
                bus.ld_valid = 1'b0;
            end else begin
                step();
            end
        end
        check("idle_valid", 32'(bus.so_valid), 32'd0);
        check("idle_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("idle_last", 32'(bus.so_last), 32'd0);
`ifdef FFT_SER_IDX_EN
        check("idle_idx", 32'(bus.so_idx), 32'd0);
`endif
    endtask

    initial begin
        rst          = 1'b1;
        bus.ld_valid = 1'b0;
        bus.so_ready = 1'b0;
        bus.ld_r     = '0;
        bus.ld_i     = '0;

        // Reset state.
        step();
        step();
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_so_valid", 32'(bus.so_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_so_r", 32'(bus.so_r), 32'd0);
        check("rst_so_i", 32'(bus.so_i), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_valid", 32'(bus.so_valid), 32'd0);
        check("post_rst_ld_ready", 32'(bus.ld_ready), 32'd1);

        // Ramp frame, no stalls.
        load_frame(0);
        stream_frame(0, -1, 0, -1, -1);
        check("ramp_ovf", 32'(ovf), 32'd0);

        // Backpressure at bin 7.
        load_frame(1);
        stream_frame(1, 7, 5, -1, -1);
        check("bp_ovf", 32'(ovf), 32'd0);

        // Overrun at bin 3: buffer untouched, ovf sticky.
        load_frame(3);
        stream_frame(3, -1, 0, 3, -1);
        check("ovr_ovf_after", 32'(ovf), 32'd1);
        step();
        check("ovr_ovf_idle", 32'(ovf), 32'd1);

        // Next frame keeps ovf, then reset lands while bin 12 is presented.
        load_frame(4);
        check("ovr_ovf_next_frame", 32'(ovf), 32'd1);
        stream_frame(4, -1, 0, -1, 12);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.so_valid), 32'd0);
        check("midrst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_so_r", 32'(bus.so_r), 32'd0);
        check("midrst_so_i", 32'(bus.so_i), 32'd0);
        check("midrst_last", 32'(bus.so_last), 32'd0);
        bus.so_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        load_frame(1);
        stream_frame(1, -1, 0, -1, -1);

        // Back-to-back: ld_valid held, frame B waits on ld_r during frame A.
        drive_frame(3);
        bus.ld_valid = 1'b1;
        step();
        drive_frame(4);
        stream_frame(3, -1, 0, -1, -1);
        step();
        bus.ld_valid = 1'b0;
        stream_frame(4, -1, 0, -1, -1);
        check("b2b_ovf", 32'(ovf), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fft_out_serializer
